// File: rtl/decoder_2to4_pulse.sv
// decoder_2to4_pulse: registered 2-to-4 decoder with valid/ready accept and stretched one-hot strobe
// Ports: clk, rst (sync, active-high); en gates new accepts; d/d_par/d_valid/d_ready input handshake;
// y one-hot strobe held PULSE_LEN cycles then GAP_LEN idle cycles; y_valid = |y; busy outside IDLE;
// err one-cycle parity error. Optional parity check enabled by defining DEC24_PARITY_EN.
module decoder_2to4_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] d,
  input  logic       d_par,
  input  logic       d_valid,
  output logic       d_ready,
  output logic [3:0] y,
  output logic       y_valid,
  output logic       busy,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_y, w_y_nxt;
  logic       r_err, w_err_nxt;
  logic       w_accept, w_par_ok;
`ifdef DEC24_PARITY_EN
  assign w_par_ok = (d_par == ^d);
`else
  logic w_unused;
  assign w_unused = d_par;
  assign w_par_ok = 1'b1;
`endif
  assign d_ready  = (r_state == IDLE) && en && !rst;
  assign w_accept = d_valid && d_ready;
  assign y        = r_y;
  assign y_valid  = |r_y;
  assign busy     = (r_state != IDLE);
  assign err      = r_err;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        // a bad-parity code is consumed without producing a pulse
        w_err_nxt = !w_par_ok;
        if (w_par_ok) begin
          w_y_nxt     = 4'b0001 << d;
          w_cnt_nxt   = 8'(PULSE_LEN - 1);
          w_state_nxt = PULSE;
        end
      end
      PULSE: if (r_cnt != 8'd0) w_cnt_nxt = r_cnt - 8'd1;
      else begin
        w_y_nxt = 4'b0000;
        if (GAP_LEN > 0) begin
          w_cnt_nxt   = 8'(GAP_LEN - 1);
          w_state_nxt = GAP;
        end else w_state_nxt = IDLE;
      end
      GAP: if (r_cnt != 8'd0) w_cnt_nxt = r_cnt - 8'd1;
      else w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_y     <= 4'b0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      r_err   <= w_err_nxt;
    end
  end
endmodule

// File: tb/tb_decoder_2to4_pulse.sv
// tb_decoder_2to4_pulse: directed self-checking bench for decoder_2to4_pulse
module tb_decoder_2to4_pulse;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] d = 2'b00;
  logic       d_par = 1'b0;
  logic       d_valid = 1'b0;
  logic       d_ready, y_valid, busy, err;
  logic [3:0] y;
  logic       f_d_ready, f_y_valid, f_busy, f_err;
  logic [3:0] f_y;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  decoder_2to4_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_par(d_par), .d_valid(d_valid),
    .d_ready(d_ready), .y(y), .y_valid(y_valid), .busy(busy), .err(err));
  decoder_2to4_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) u_fast (
    .clk(clk), .rst(rst), .en(en), .d(d), .d_par(d_par), .d_valid(d_valid),
    .d_ready(f_d_ready), .y(f_y), .y_valid(f_y_valid), .busy(f_busy), .err(f_err));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    d_valid = 1'b0;
    tick();
    rst = 1'b0;
    en = 1'b1;
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; d = 2'b01; d_par = 1'b1; d_valid = 1'b1;
    tick();
    tick();
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL reset_y got %b want 0000", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_y_valid got %b want 0", y_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready got %b want 0", d_ready); end
    rst = 1'b0; d_valid = 1'b0;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL release_d_ready got %b want 1", d_ready); end
  endtask
  task automatic test_decode();
    logic [1:0] c;
    logic [3:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      c = 2'(3 - k);
      e = 4'b0001 << c;
      d = c; d_par = ^c; d_valid = 1'b1;
      #1;
      checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL dec_ready code %0d got %b want 1", c, d_ready); end
      tick();
      d_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        checks++; if (y !== e || y_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL dec_pulse code %0d cyc %0d got y=%b v=%b b=%b want y=%b v=1 b=1", c, i, y, y_valid, busy, e); end
      end
      tick();
      checks++; if (y !== 4'b0000 || y_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL dec_gap code %0d got y=%b v=%b b=%b want y=0000 v=0 b=1", c, y, y_valid, busy); end
      tick();
      checks++; if (busy !== 1'b0 || d_ready !== 1'b1) begin errors++; $display("FAIL dec_idle code %0d got b=%b r=%b want b=0 r=1", c, busy, d_ready); end
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] e, fe;
    do_reset();
    d = 2'b10; d_par = 1'b1; d_valid = 1'b1;
    #1;
    for (int k = 0; k < 18; k++) begin
      e  = (k % 6 >= 1 && k % 6 <= 4) ? 4'b0100 : 4'b0000;
      fe = (k % 2 == 1) ? 4'b0100 : 4'b0000;
      checks++; if (y !== e) begin errors++; $display("FAIL b2b_y k=%0d got %b want %b", k, y, e); end
      checks++; if (d_ready !== (k % 6 == 0)) begin errors++; $display("FAIL b2b_ready k=%0d got %b want %b", k, d_ready, k % 6 == 0); end
      checks++; if (f_y !== fe) begin errors++; $display("FAIL b2b_fast_y k=%0d got %b want %b", k, f_y, fe); end
      checks++; if (f_d_ready !== (k % 2 == 0)) begin errors++; $display("FAIL b2b_fast_ready k=%0d got %b want %b", k, f_d_ready, k % 2 == 0); end
      tick();
    end
    d_valid = 1'b0;
  endtask
  task automatic test_en_drop();
    do_reset();
    d = 2'b00; d_par = 1'b0; d_valid = 1'b1;
    #1;
    tick();
    d_valid = 1'b0;
    tick();
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (y !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL en_pulse cyc %0d got y=%b b=%b want y=0001 b=1", i, y, busy); end
    end
    tick();
    checks++; if (y !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL en_gap got y=%b b=%b want y=0000 b=1", y, busy); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (busy !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL en_low_idle cyc %0d got b=%b r=%b want b=0 r=0", i, busy, d_ready); end
    end
    en = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL en_back_ready got %b want 1", d_ready); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    d = 2'b01; d_par = 1'b1; d_valid = 1'b1;
    #1;
    tick();
    d_valid = 1'b0;
    checks++; if (y !== 4'b0010) begin errors++; $display("FAIL mid_first got %b want 0010", y); end
    tick();
    rst = 1'b1; d_valid = 1'b1;
    tick();
    checks++; if (y !== 4'b0000 || y_valid !== 1'b0 || busy !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got y=%b v=%b b=%b r=%b want 0000 0 0 0", y, y_valid, busy, d_ready); end
    tick();
    checks++; if (busy !== 1'b0 || y !== 4'b0000) begin errors++; $display("FAIL mid_no_accept got b=%b y=%b want b=0 y=0000", busy, y); end
    rst = 1'b0; d_valid = 1'b0;
    #1;
    checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", d_ready); end
  endtask
  task automatic test_parity();
    do_reset();
    d = 2'b01; d_par = 1'b0; d_valid = 1'b1;
    #1;
    tick();
    d_valid = 1'b0;
`ifdef DEC24_PARITY_EN
    checks++; if (err !== 1'b1 || y !== 4'b0000 || busy !== 1'b0 || d_ready !== 1'b1) begin errors++; $display("FAIL par_bad got e=%b y=%b b=%b r=%b want 1 0000 0 1", err, y, busy, d_ready); end
    tick();
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL par_err_clear got e=%b b=%b want 0 0", err, busy); end
    d_par = 1'b1; d_valid = 1'b1;
    #1;
    tick();
    d_valid = 1'b0;
    checks++; if (y !== 4'b0010 || err !== 1'b0) begin errors++; $display("FAIL par_good got y=%b e=%b want 0010 0", y, err); end
`else
    checks++; if (y !== 4'b0010 || err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL par_ignored got y=%b e=%b b=%b want 0010 0 1", y, err, busy); end
`endif
    do_reset();
  endtask
  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
